root_nonrestoring_param: RTL and testbench



---
 rtl/root_nonrestoring_param.sv | 133 +++++++++++++
 tb/tb_root_nonrestoring_param.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/root_nonrestoring_param.sv
// Iterative radix-2 non-restoring square root: q = floor(sqrt(d)), r = d - q*q.
// Ports: clk, clrn (sync active-low), d/load in; q, r, busy, ready, count out.
// Macro ROOT_NONRESTORING_REMFIX_EN adds a FIX cycle that corrects r.
module root_nonrestoring_param #(
  parameter int WIDTH = 32,
  parameter int CW    = $clog2(WIDTH/2)
) (
  input  logic               clk,
  input  logic               clrn,
  input  logic [WIDTH-1:0]   d,
  input  logic               load,
  output logic [WIDTH/2-1:0] q,
  output logic [WIDTH/2:0]   r,
  output logic               busy,
  output logic               ready,
  output logic [CW-1:0]      count
);

  localparam int N = WIDTH / 2;

`ifdef ROOT_NONRESTORING_REMFIX_EN
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd3
  } state_t;
`endif

  state_t           state_q, state_d;
  logic [WIDTH-1:0] rad_q, rad_d;
  logic [N+1:0]     rem_q, rem_d;
  logic [N-1:0]     root_q, root_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [N-1:0]     q_q, q_d;
  logic [N:0]       r_q, r_d;

  logic [N+1:0]     shifted;
  logic [N+1:0]     step;
  logic [N+1:0]     fixed;

  // Sign of the previous partial remainder picks subtract or add.
  assign shifted = {rem_q[N-1:0], rad_q[WIDTH-1 -: 2]};
  assign step    = rem_q[N+1] ? shifted + {root_q, 2'b11}
                              : shifted - {root_q, 2'b01};
  assign fixed   = rem_q + {1'b0, root_q, 1'b1};

  always_comb begin
    state_d = state_q;
    rad_d   = rad_q;
    rem_d   = rem_q;
    root_d  = root_q;
    cnt_d   = cnt_q;
    q_d     = q_q;
    r_d     = r_q;
    unique case (state_q)
      IDLE, DONE: begin
        if (load) begin
          state_d = CALC;
          rad_d   = d;
          rem_d   = '0;
          root_d  = '0;
          cnt_d   = '0;
        end else begin
          state_d = IDLE;
        end
      end
      CALC: begin
        rad_d  = rad_q << 2;
        rem_d  = step;
        root_d = {root_q[N-2:0], ~step[N+1]};
        if (cnt_q == CW'(N - 1)) begin
          cnt_d = '0;
`ifdef ROOT_NONRESTORING_REMFIX_EN
          state_d = FIX;
`else
          state_d = DONE;
          q_d     = root_d;
          r_d     = step[N:0];
`endif
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
`ifdef ROOT_NONRESTORING_REMFIX_EN
      FIX: begin
        rem_d   = rem_q[N+1] ? fixed : rem_q;
        state_d = DONE;
        q_d     = root_q;
        r_d     = rem_d[N:0];
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrn) begin
      state_q <= IDLE;
      rad_q   <= '0;
      rem_q   <= '0;
      root_q  <= '0;
      cnt_q   <= '0;
      q_q     <= '0;
      r_q     <= '0;
    end else begin
      state_q <= state_d;
      rad_q   <= rad_d;
      rem_q   <= rem_d;
      root_q  <= root_d;
      cnt_q   <= cnt_d;
      q_q     <= q_d;
      r_q     <= r_d;
    end
  end

`ifdef ROOT_NONRESTORING_REMFIX_EN
  assign busy = (state_q == CALC) || (state_q == FIX);
`else
  assign busy = (state_q == CALC);
`endif
  assign ready = (state_q == DONE);
  assign q     = q_q;
  assign r     = r_q;
  assign count = cnt_q;

endmodule

// File: tb/tb_root_nonrestoring_param.sv
// Bench for root_nonrestoring_param at WIDTH=32 against a cycle-count model
// computing results with plain integer arithmetic; honours the REMFIX macro.
module tb_root_nonrestoring_param;

  localparam int W = 32;
  localparam int N = W / 2;
`ifdef ROOT_NONRESTORING_REMFIX_EN
  localparam int LAT = N + 2;
`else
  localparam int LAT = N + 1;
`endif

  logic        clk = 1'b0;
  logic        clrn = 1'b0;
  logic        load = 1'b0;
  logic [31:0] d = '0;
  logic [15:0] q;
  logic [16:0] r;
  logic        busy, ready;
  logic [3:0]  count;

  int n_cmp = 0;
  int n_bad = 0;
  bit chk_en = 1'b0;

  root_nonrestoring_param #(.WIDTH(W)) dut (
    .clk(clk), .clrn(clrn), .d(d), .load(load),
    .q(q), .r(r), .busy(busy), .ready(ready), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] m_sqrt(input logic [31:0] v);
    longint unsigned x, t;
    x = 0;
    for (int b = 15; b >= 0; b--) begin
      t = x + (64'd1 << b);
      if (t * t <= 64'(v)) x = t;
    end
    return 16'(x);
  endfunction

  // Without correction the raw remainder is negative exactly when the
  // last root bit came out 0.
  function automatic logic [16:0] m_rem(input logic [31:0] v);
    longint unsigned s, t;
    s = 64'(m_sqrt(v));
    t = 64'(v) - s * s;
`ifdef ROOT_NONRESTORING_REMFIX_EN
    return 17'(t);
`else
    if (s % 2 == 1) return 17'(t);
    return 17'(t - (2 * s + 1));
`endif
  endfunction

  bit          m_pend = 1'b0;
  int          m_k = 0;
  logic [31:0] m_d = '0;
  logic [15:0] m_q = '0;
  logic [16:0] m_r = '0;
  logic        e_busy, e_ready;
  logic [3:0]  e_count;

  always @(posedge clk) begin
    if (!clrn) begin
      m_pend <= 1'b0;
      m_k    <= 0;
      m_q    <= '0;
      m_r    <= '0;
    end else if (load && (!m_pend || m_k == LAT - 1)) begin
      m_pend <= 1'b1;
      m_k    <= 0;
      m_d    <= d;
    end else if (m_pend) begin
      if (m_k == LAT - 1) m_pend <= 1'b0;
      else m_k <= m_k + 1;
      if (m_k + 1 == LAT - 1) begin
        m_q <= m_sqrt(m_d);
        m_r <= m_rem(m_d);
      end
    end
  end

  assign e_busy  = m_pend && (m_k < LAT - 1);
  assign e_ready = m_pend && (m_k == LAT - 1);
  assign e_count = (e_busy && m_k < N) ? 4'(m_k) : 4'd0;

  always @(negedge clk) begin
    if (chk_en) begin
      chk("busy", 64'(busy), 64'(e_busy));
      chk("ready", 64'(ready), 64'(e_ready));
      chk("count", 64'(count), 64'(e_count));
      chk("q", 64'(q), 64'(m_q));
      chk("r", 64'(r), 64'(m_r));
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic start(input logic [31:0] v);
    load = 1'b1;
    d    = v;
    tick();
    load = 1'b0;
  endtask

  task automatic wait_ready(output bit ok, output int nb);
    ok = 1'b0;
    nb = 0;
    for (int i = 0; i < 40; i++) begin
      if (ready) begin
        ok = 1'b1;
        break;
      end
      if (busy) nb++;
      tick();
    end
  endtask

  function automatic logic [31:0] rand_d();
    logic [31:0] s;
    int sel;
    sel = $urandom_range(0, 5);
    s   = 32'($urandom_range(1, 65535));
    if (sel == 0) return $urandom;
    if (sel == 1) return 32'($urandom_range(0, 300));
    if (sel == 2) return s * s;
    if (sel == 3) return s * s + 2 * s;
    if (sel == 4) return 32'hFFFF_FFFF - 32'($urandom_range(0, 1000));
    return s * s - 1;
  endfunction

  logic [31:0] b2b_d [4];
  logic [15:0] b2b_q [4];
  logic [16:0] b2b_r [4];

  initial begin
    bit ok;
    int nb, nrdy, rst_at;
    bit b2b;
    logic [31:0] pin_v;

    pin_v = 32'hC000_0000;
    chk("model_sqrt_c0", 64'(m_sqrt(pin_v)), 64'h DDB3);
    chk("model_rem_c0", 64'(m_rem(pin_v)), 64'h174D7);
    pin_v = 32'hFFFF_FFFF;
    chk("model_sqrt_max", 64'(m_sqrt(pin_v)), 64'hFFFF);

    clrn = 1'b0;
    tick();
    chk_en = 1'b1;
    tick();
    chk("rst_q", 64'(q), 0);
    chk("rst_r", 64'(r), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_ready", 64'(ready), 0);
    chk("rst_count", 64'(count), 0);
    clrn = 1'b1;
    tick();

    start(32'hC000_0000);
    wait_ready(ok, nb);
    chk("c0_ready_seen", 64'(ok), 1);
    chk("c0_busy_cycles", 64'(nb), 64'(LAT - 1));
    chk("c0_q", 64'(q), 64'hDDB3);
    chk("c0_r", 64'(r), 64'h174D7);
    chk("c0_count", 64'(count), 0);
    tick();
    chk("c0_ready_one_cycle", 64'(ready), 0);

    b2b_d[0] = 32'd0;  b2b_q[0] = 16'd0;
    b2b_d[1] = 32'd1;  b2b_q[1] = 16'd1;
    b2b_d[2] = 32'd8;  b2b_q[2] = 16'd2;
    b2b_d[3] = 32'hFFFF_FFFF; b2b_q[3] = 16'hFFFF;
`ifdef ROOT_NONRESTORING_REMFIX_EN
    b2b_r[0] = 17'h0;  b2b_r[2] = 17'h4;
`else
    b2b_r[0] = 17'h1FFFF; b2b_r[2] = 17'h1FFFF;
`endif
    b2b_r[1] = 17'h0;  b2b_r[3] = 17'h1FFFE;
    start(b2b_d[0]);
    for (int i = 0; i < 4; i++) begin
      wait_ready(ok, nb);
      chk("b2b_ready_seen", 64'(ok), 1);
      chk("b2b_busy_cycles", 64'(nb), 64'(LAT - 1));
      chk("b2b_q", 64'(q), 64'(b2b_q[i]));
      chk("b2b_r", 64'(r), 64'(b2b_r[i]));
      if (i < 3) start(b2b_d[i + 1]);
    end
    tick();

    start(32'h10);
    nrdy = 0;
    for (int i = 1; i <= LAT + 4; i++) begin
      if (ready) begin
        nrdy++;
        chk("spur_q", 64'(q), 4);
`ifdef ROOT_NONRESTORING_REMFIX_EN
        chk("spur_r", 64'(r), 0);
`else
        chk("spur_r", 64'(r), 64'h1FFF7);
`endif
      end
      load = (i == 3 || i == 10);
      d    = $urandom;
      tick();
    end
    load = 1'b0;
    chk("spur_ready_pulses", 64'(nrdy), 1);

    start(32'hC000_0000);
    repeat (6) tick();
    clrn = 1'b0;
    tick();
    clrn = 1'b1;
    chk("mid_rst_q", 64'(q), 0);
    chk("mid_rst_r", 64'(r), 0);
    chk("mid_rst_busy", 64'(busy), 0);
    chk("mid_rst_ready", 64'(ready), 0);
    chk("mid_rst_count", 64'(count), 0);
    nrdy = 0;
    for (int i = 0; i < 25; i++) begin
      if (ready) nrdy++;
      tick();
    end
    chk("mid_rst_no_ready", 64'(nrdy), 0);
    start(32'd9);
    wait_ready(ok, nb);
    chk("nine_ready_seen", 64'(ok), 1);
    chk("nine_q", 64'(q), 3);
    chk("nine_r", 64'(r), 0);
    tick();

    b2b = 1'b0;
    for (int op = 0; op < 400; op++) begin
      start(rand_d());
      rst_at = (op % 37 == 5) ? int'($urandom_range(1, 15)) : -1;
      ok = 1'b0;
      for (int c = 0; c < 40; c++) begin
        if (ready) begin
          ok = 1'b1;
          break;
        end
        if (rst_at >= 0 && c == rst_at + 2) break;
        clrn = !(c == rst_at);
        load = ($urandom_range(0, 3) == 0);
        d    = $urandom;
        tick();
      end
      clrn = 1'b1;
      if (rst_at < 0) chk("rand_ready_seen", 64'(ok), 1);
      b2b = ok && ($urandom_range(0, 1) == 1);
      if (!b2b) begin
        load = 1'b0;
        repeat ($urandom_range(0, 3)) tick();
      end
    end
    load = 1'b0;
    repeat (LAT + 4) tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
